apu_fp_cast_pipe: RTL
=====================

// Module: apu_fp_cast_pipe
// PURPOSE
// - Shared FP cast unit for the APU cluster: FP32 -> INT32 (F2I) and INT32 -> FP32 (I2F).
// - Sits downstream of the cluster interconnect/arbiter: takes one granted request per cycle with operands, op and tag.
// - Returns result, status flags and tag after a fixed C_CAST_PIPE_REGS-cycle pipeline, with valid/ready backpressure.
// PARAMETERS
// - WAPUTAG   default 2                   tag width, passed through unchanged
// - PIPE_REGS default C_CAST_PIPE_REGS(1) pipeline depth, >=1; latency in cycles
// PORTS
// - clk_i       in   1              clock
// - rst_i       in   1              synchronous, active-high reset
// - valid_i     in   1              request valid
// - ready_o     out  1              request accepted when valid_i&ready_o
// - op_i        in   WOP_CAST(1)    0=F2I, 1=I2F
// - operand_i   in   FP_WIDTH(32)   FP32 bits (F2I) or signed INT32 (I2F)
// - flags_ds_i  in   NDSFLAGS_CAST(3) rounding mode for I2F: 000 RNE, 001 RTZ, others=RNE
// - tag_i       in   WAPUTAG        request tag
// - valid_o     out  1              result valid
// - ready_i     in   1              consumer accepts when valid_o&ready_i
// - result_o    out  32             cast result
// - flags_us_o  out  NUSFLAGS_CAST(8) [0]NX [1]UF [2]OF [3]DZ(=0) [4]NV [7:5]=0
// - tag_o       out  WAPUTAG        tag of the result
// BEHAVIOUR
// - Reset: every valid stage bit cleared; valid_o=0, result_o=0, flags_us_o=0, tag_o=0.
// - Global enable en = ~valid_o | ready_i; ready_o = en. All stages shift only when en=1.
// - Cast logic is combinational on the inputs, captured in stage 1, then shifted through PIPE_REGS-1 further stages.
// - Latency: accept at cycle N -> valid_o at N+PIPE_REGS if not stalled; throughput 1/cycle.
// - Stall: valid_o=1 & ready_i=0 freezes all stages; outputs stable, ready_o=0, no drop or duplication.
// - Bubbles advance while stalled-free; bubbles do not compact while a stall is held.
// - F2I: round toward zero always. |x|<1 -> 0, NX if x!=0. Denormals -> 0, NX.
//   In range [-2^31, 2^31-1] -> truncated value, NX if fraction bits lost.
//   NaN or +out-of-range or +Inf -> C_MAX_INT, NV. -out-of-range or -Inf -> C_MIN_INT, NV. NV excludes NX.
// - I2F: 0 -> C_ZERO_P. Sign-magnitude with 32-bit magnitude (C_MIN_INT magnitude 2^31 handled unsigned).
//   Leading-zero normalise, 24-bit significand, guard+sticky rounding per flags_ds_i.
//   Rounding carry-out bumps exponent. NX when any bit discarded. Never OF/UF/NV.
// - Reset mid-operation flushes all in-flight requests; none delivered after rst_i deasserts.
// - Simultaneous accept and output handshake in one cycle is legal and keeps full throughput.
// STRUCTURE
// - apu_cluster_package gains: cast op encoding constants (CAST_F2I=0, CAST_I2F=1), flag bit index constants,
//   rounding-mode constants (RM_RNE, RM_RTZ).
// - Existing package values already used here: C_MAX_INT, C_MIN_INT, C_ZERO_P, FP_WIDTH, SIG_WIDTH, EXP_WIDTH.
// - One sub-module: apu_lzc32 (combinational 32-bit leading-zero count), used by I2F normalisation.
// - Pipeline is a generate loop of PIPE_REGS stages of {valid, result, flags, tag}.
// TESTING
// - F2I 0xC0700000 (-3.75) -> 0xFFFFFFFD, flags NX=1, after PIPE_REGS cycles, tag preserved.
// - F2I edges:
//   - 0x7FC00000 -> 0x7FFFFFFF, NV.
//   - 0xFF800000 -> 0x80000000, NV.
//   - 0xCF000000 -> 0x80000000, no flags.
//   - 0x4F000000 -> 0x7FFFFFFF, NV.
// - I2F RNE:
//   - 0x01000001 -> 0x4B800000, NX.
//   - 0x01000003 -> 0x4B800002, NX.
//   - 0x80000000 -> 0xCF000000, exact.
//   - 0x7FFFFFFF -> 0x4F000000, NX.
// - I2F RTZ: 0x7FFFFFFF -> 0x4EFFFFFF, NX. 0 -> 0x00000000, no flags.
// - Backpressure: stream 8 back-to-back ops, ready_i low 3 cycles mid-stream ->
//   all 8 results in order with correct tags, outputs stable while stalled.
// - Reset mid-stream: rst_i high 1 cycle with 1..PIPE_REGS in flight -> valid_o=0 next cycle, no stale results after.

Source files
------------

// File: rtl/apu_cluster_package.sv
`default_nettype none
// ============================================================================
// Module      : apu_cluster_package
// Description : Shared APU cluster constants: FP32 layout, integer limits,
//               cast-unit op/flag/rounding encodings and a flag packer.
// Revision    : 1.0 - initial cast-unit additions
// ============================================================================
package apu_cluster_package;

    // FP32 layout
    localparam int FP_WIDTH  = 32;
    localparam int SIG_WIDTH = 23;
    localparam int EXP_WIDTH = 8;

    // Integer limits and canonical zero
    localparam logic [FP_WIDTH-1:0] C_MAX_INT = 32'h7FFF_FFFF;
    localparam logic [FP_WIDTH-1:0] C_MIN_INT = 32'h8000_0000;
    localparam logic [FP_WIDTH-1:0] C_ZERO_P  = 32'h0000_0000;

    // Cast unit interface widths
    localparam int C_CAST_PIPE_REGS = 1;
    localparam int WOP_CAST         = 1;
    localparam int NDSFLAGS_CAST    = 3;
    localparam int NUSFLAGS_CAST    = 8;

    // Cast op encoding
    localparam logic [WOP_CAST-1:0] CAST_F2I = 1'b0;
    localparam logic [WOP_CAST-1:0] CAST_I2F = 1'b1;

    // Upstream status flag bit positions
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    // Rounding modes carried on flags_ds_i
    localparam logic [NDSFLAGS_CAST-1:0] RM_RNE = 3'b000;
    localparam logic [NDSFLAGS_CAST-1:0] RM_RTZ = 3'b001;

    // Exponent landmarks: 2^0 and 2^31 in biased form
    localparam logic [EXP_WIDTH-1:0] C_EXP_BIAS  = 8'd127;
    localparam logic [EXP_WIDTH-1:0] C_EXP_2P31  = 8'd158;

    // Cast units only ever raise NX or NV; the rest stay zero
    function automatic logic [NUSFLAGS_CAST-1:0] cast_flags(input logic nx, input logic nv);
        logic [NUSFLAGS_CAST-1:0] f;
        f          = '0;
        f[FLAG_NX] = nx;
        f[FLAG_UF] = 1'b0;
        f[FLAG_OF] = 1'b0;
        f[FLAG_DZ] = 1'b0;
        f[FLAG_NV] = nv;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_lzc32.sv
`default_nettype none
// ============================================================================
// Module      : apu_lzc32
// Description : Combinational 32-bit leading-zero counter. cnt_o is 32 and
//               zero_o is set when the input is all zeros.
// Revision    : 1.0 - initial
// ============================================================================
module apu_lzc32 (
    input  logic [31:0] in_i,
    output logic [5:0]  cnt_o,
    output logic        zero_o
);

    logic w_found;

    // Scan from MSB down, counting zeros until the first set bit
    always_comb begin
        cnt_o   = '0;
        w_found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!w_found) begin
                if (in_i[i]) begin
                    w_found = 1'b1;
                end else begin
                    cnt_o = cnt_o + 6'd1;
                end
            end
        end
    end

    assign zero_o = ~w_found;

endmodule
`default_nettype wire

// File: rtl/apu_fp_cast_pipe.sv
`default_nettype none
// ============================================================================
// Module      : apu_fp_cast_pipe
// Description : Shared FP32<->INT32 cast unit. Combinational cast on the
//               request, then PIPE_REGS register stages with a single global
//               valid/ready enable.
// Revision    : 1.0 - initial
// ============================================================================
module apu_fp_cast_pipe
    import apu_cluster_package::*;
#(
    parameter int WAPUTAG   = 2,
    parameter int PIPE_REGS = C_CAST_PIPE_REGS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [WOP_CAST-1:0]       op_i,
    input  logic [FP_WIDTH-1:0]       operand_i,
    input  logic [NDSFLAGS_CAST-1:0]  flags_ds_i,
    input  logic [WAPUTAG-1:0]        tag_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [FP_WIDTH-1:0]       result_o,
    output logic [NUSFLAGS_CAST-1:0]  flags_us_o,
    output logic [WAPUTAG-1:0]        tag_o
);

    // ------------------------------------------------------------------
    // F2I: round toward zero
    // ------------------------------------------------------------------
    logic                   w_f_sign;
    logic [EXP_WIDTH-1:0]   w_f_exp;
    logic [SIG_WIDTH-1:0]   w_f_man;
    logic [5:0]             w_f_shamt;
    logic [63:0]            w_f_shift;
    logic [31:0]            w_f_mag;
    logic [31:0]            w_f2i_res;
    logic                   w_f2i_nx;
    logic                   w_f2i_nv;

    assign w_f_sign = operand_i[FP_WIDTH-1];
    assign w_f_exp  = operand_i[FP_WIDTH-2 -: EXP_WIDTH];
    assign w_f_man  = operand_i[SIG_WIDTH-1:0];

    // Classify the float and truncate; the hidden-one significand is placed
    // so that bit 32 of w_f_shift carries weight 2^0
    always_comb begin
        w_f2i_res = '0;
        w_f2i_nx  = 1'b0;
        w_f2i_nv  = 1'b0;
        w_f_shamt = '0;
        w_f_shift = '0;
        w_f_mag   = '0;
        if (w_f_exp == '1) begin
            // NaN saturates positive; infinities saturate by sign
            w_f2i_nv  = 1'b1;
            w_f2i_res = (w_f_sign && (w_f_man == '0)) ? C_MIN_INT : C_MAX_INT;
        end else if (w_f_exp < C_EXP_BIAS) begin
            // |x| < 1 including denormals
            w_f2i_res = '0;
            w_f2i_nx  = (w_f_exp != '0) || (w_f_man != '0);
        end else if (w_f_exp >= C_EXP_2P31) begin
            // Only exactly -2^31 is representable at or above 2^31
            if (w_f_sign && (w_f_exp == C_EXP_2P31) && (w_f_man == '0)) begin
                w_f2i_res = C_MIN_INT;
            end else begin
                w_f2i_nv  = 1'b1;
                w_f2i_res = w_f_sign ? C_MIN_INT : C_MAX_INT;
            end
        end else begin
            w_f_shamt = 6'(w_f_exp - C_EXP_BIAS) + 6'd9;
            w_f_shift = {40'd0, 1'b1, w_f_man} << w_f_shamt;
            w_f_mag   = w_f_shift[63:32];
            w_f2i_nx  = |w_f_shift[31:0];
            w_f2i_res = w_f_sign ? (~w_f_mag + 32'd1) : w_f_mag;
        end
    end

    // ------------------------------------------------------------------
    // I2F: sign-magnitude, normalise, round to 24-bit significand
    // ------------------------------------------------------------------
    logic                   w_i_sign;
    logic [31:0]            w_i_mag;
    logic [5:0]             w_i_lz;
    logic                   w_i_zero;
    logic [31:0]            w_i_norm;
    logic                   w_i_guard;
    logic                   w_i_sticky;
    logic                   w_i_round_up;
    logic [24:0]            w_i_sig;
    logic [EXP_WIDTH-1:0]   w_i_exp;
    logic [SIG_WIDTH-1:0]   w_i_man;
    logic [31:0]            w_i2f_res;
    logic                   w_i2f_nx;

    assign w_i_sign = operand_i[31];
    // Magnitude is unsigned so INT_MIN yields 2^31 cleanly
    assign w_i_mag  = w_i_sign ? (~operand_i + 32'd1) : operand_i;

    apu_lzc32 u_lzc (
        .in_i   (w_i_mag),
        .cnt_o  (w_i_lz),
        .zero_o (w_i_zero)
    );

    assign w_i_norm   = w_i_mag << w_i_lz;
    assign w_i_guard  = w_i_norm[7];
    assign w_i_sticky = |w_i_norm[6:0];

    // Rounding decision; unknown modes fall back to round-to-nearest-even
    always_comb begin
        w_i_round_up = 1'b0;
        case (flags_ds_i)
            RM_RTZ:  w_i_round_up = 1'b0;
            RM_RNE:  w_i_round_up = w_i_guard & (w_i_sticky | w_i_norm[8]);
            default: w_i_round_up = w_i_guard & (w_i_sticky | w_i_norm[8]);
        endcase
    end

    // Round, absorb a carry-out into the exponent, and assemble
    always_comb begin
        w_i_sig   = {1'b0, w_i_norm[31:8]} + {24'd0, w_i_round_up};
        w_i_exp   = C_EXP_2P31 - {2'b00, w_i_lz} + {7'd0, w_i_sig[24]};
        w_i_man   = w_i_sig[24] ? w_i_sig[23:1] : w_i_sig[22:0];
        w_i2f_res = w_i_zero ? C_ZERO_P : {w_i_sign, w_i_exp, w_i_man};
        w_i2f_nx  = ~w_i_zero & (w_i_guard | w_i_sticky);
    end

    // ------------------------------------------------------------------
    // Op select into stage-1 input
    // ------------------------------------------------------------------
    logic [FP_WIDTH-1:0]      result_d;
    logic [NUSFLAGS_CAST-1:0] flags_d;

    // Pick the result of the requested cast direction
    always_comb begin
        result_d = '0;
        flags_d  = '0;
        case (op_i)
            CAST_F2I: begin
                result_d = w_f2i_res;
                flags_d  = cast_flags(w_f2i_nx, w_f2i_nv);
            end
            default: begin
                result_d = w_i2f_res;
                flags_d  = cast_flags(w_i2f_nx, 1'b0);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline: element 0 is the stage-1 input, element PIPE_REGS the output
    // ------------------------------------------------------------------
    logic                                   w_en;
    logic [PIPE_REGS:0]                     w_valid_s;
    logic [PIPE_REGS:0][FP_WIDTH-1:0]       w_result_s;
    logic [PIPE_REGS:0][NUSFLAGS_CAST-1:0]  w_flags_s;
    logic [PIPE_REGS:0][WAPUTAG-1:0]        w_tag_s;

    assign w_valid_s[0]  = valid_i;
    assign w_result_s[0] = result_d;
    assign w_flags_s[0]  = flags_d;
    assign w_tag_s[0]    = tag_i;

    // One enable for every stage: bubbles never compact under a stall
    assign w_en    = ~valid_o | ready_i;
    assign ready_o = w_en;

    generate
        for (genvar k = 0; k < PIPE_REGS; k++) begin : g_stage
            logic                      valid_q;
            logic [FP_WIDTH-1:0]       result_q;
            logic [NUSFLAGS_CAST-1:0]  flags_q;
            logic [WAPUTAG-1:0]        tag_q;

            // Shift the previous stage in whenever the pipe may advance
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q  <= 1'b0;
                    result_q <= '0;
                    flags_q  <= '0;
                    tag_q    <= '0;
                end else if (w_en) begin
                    valid_q  <= w_valid_s[k];
                    result_q <= w_result_s[k];
                    flags_q  <= w_flags_s[k];
                    tag_q    <= w_tag_s[k];
                end
            end

            assign w_valid_s[k+1]  = valid_q;
            assign w_result_s[k+1] = result_q;
            assign w_flags_s[k+1]  = flags_q;
            assign w_tag_s[k+1]    = tag_q;
        end
    endgenerate

    assign valid_o    = w_valid_s[PIPE_REGS];
    assign result_o   = w_result_s[PIPE_REGS];
    assign flags_us_o = w_flags_s[PIPE_REGS];
    assign tag_o      = w_tag_s[PIPE_REGS];

endmodule
`default_nettype wire
